// File: rtl/commit_ring_alloc.sv
// ---------------------------------------------------------------------------
// commit_ring_alloc
//
// Purpose:
//   Owns the circular commit buffer that sits upstream of the ALU scheduler.
//   Each cycle it hands out up to NDEC in-order slots to freshly decoded
//   instructions, records completion pulses from the execution units,
//   retires up to NRETIRE consecutive completed entries from the head and
//   truncates the ring on a branch-mispredict flush. The head pointer is
//   exported as the scheduler's rotate amount (start_commit).
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   alloc_req     thermometer-coded request mask (lanes 0..k-1)
//   alloc_ok      grant for the whole request this cycle (combinational)
//   alloc_idx     per-lane slot index, lane i = tail+i mod NCOMMIT
//   done_set      one-cycle completion pulses, one bit per entry
//   flush_valid   mispredict flush
//   flush_idx     index of the mispredicted branch (this entry survives)
//   retire_mask   entries retired this cycle (registered pulse)
//   retire_count  popcount of retire_mask
//   commit_valid  live-entry mask
//   commit_head   oldest live entry (start_commit)
//   free_count    NCOMMIT minus occupied entries
// ---------------------------------------------------------------------------
module commit_ring_alloc #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int NDEC     = 4,
  parameter int NRETIRE  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NDEC-1:0]            alloc_req,
  output logic                       alloc_ok,
  output logic [NDEC*LNCOMMIT-1:0]   alloc_idx,
  input  logic [NCOMMIT-1:0]         done_set,
  input  logic                       flush_valid,
  input  logic [LNCOMMIT-1:0]        flush_idx,
  output logic [NCOMMIT-1:0]         retire_mask,
  output logic [LNCOMMIT-1:0]        retire_count,
  output logic [NCOMMIT-1:0]         commit_valid,
  output logic [LNCOMMIT-1:0]        commit_head,
  output logic [LNCOMMIT:0]          free_count
);

  // Registered ring state
  logic [LNCOMMIT-1:0] head;
  logic [LNCOMMIT-1:0] tail;
  logic [LNCOMMIT:0]   count;
  logic [NCOMMIT-1:0]  valid;
  logic [NCOMMIT-1:0]  done;

  // Next-state values
  logic [LNCOMMIT-1:0] head_next;
  logic [LNCOMMIT-1:0] tail_next;
  logic [LNCOMMIT:0]   count_next;
  logic [NCOMMIT-1:0]  valid_next;
  logic [NCOMMIT-1:0]  done_next;
  logic [NCOMMIT-1:0]  retire_mask_next;
  logic [LNCOMMIT-1:0] retire_count_next;

  // Allocation helpers
  logic [LNCOMMIT:0]   alloc_k;
  logic [NCOMMIT-1:0]  alloc_mask;
  logic [NCOMMIT-1:0]  grant_mask;
  logic [LNCOMMIT-1:0] lane_idx;

  // Retire scan helpers
  logic [NCOMMIT-1:0]  ret_mask;
  logic [LNCOMMIT-1:0] ret_cnt;
  logic [LNCOMMIT-1:0] scan_idx;
  logic                scan_stop;

  // Flush helpers
  logic [LNCOMMIT-1:0] flush_age;
  logic [LNCOMMIT-1:0] entry_age;
  logic [NCOMMIT-1:0]  survive;

  // Completion pulses only land on live entries
  logic [NCOMMIT-1:0]  done_merged;

  assign commit_valid = valid;
  assign commit_head  = head;
  assign free_count   = (LNCOMMIT+1)'(NCOMMIT) - count;

  // Request size. The request is thermometer coded, so the popcount is also
  // the number of lanes, and lanes 0..k-1 map to tail..tail+k-1.
  always_comb begin
    alloc_k = '0;
    for (int i = 0; i < NDEC; i++) begin
      alloc_k = alloc_k + (LNCOMMIT+1)'(alloc_req[i]);
    end
  end

  // Eligibility is judged against the pre-retire occupancy, so slots freed
  // by this cycle's retire only become allocatable next cycle.
  assign alloc_ok = !reset && !flush_valid && (alloc_k <= free_count);

  // Lane indices are always driven; the ring size is a power of two, so the
  // modulo is just the natural wrap of the LNCOMMIT-bit add.
  always_comb begin
    alloc_idx  = '0;
    alloc_mask = '0;
    lane_idx   = '0;
    for (int i = 0; i < NDEC; i++) begin
      lane_idx = tail + LNCOMMIT'(i);
      alloc_idx[i*LNCOMMIT +: LNCOMMIT] = lane_idx;
      if (alloc_req[i]) begin
        alloc_mask[lane_idx] = 1'b1;
      end
    end
  end

  assign grant_mask = alloc_ok ? alloc_mask : '0;

  // In-order retire: walk from head and stop at the first entry that is not
  // both live and complete. Only registered done bits are seen, so a pulse
  // becomes retirable one cycle after it arrives.
  always_comb begin
    ret_mask  = '0;
    ret_cnt   = '0;
    scan_idx  = '0;
    scan_stop = 1'b0;
    for (int i = 0; i < NRETIRE; i++) begin
      scan_idx = head + LNCOMMIT'(i);
      if (!scan_stop && valid[scan_idx] && done[scan_idx]) begin
        ret_mask[scan_idx] = 1'b1;
        ret_cnt            = ret_cnt + LNCOMMIT'(1);
      end else begin
        scan_stop = 1'b1;
      end
    end
  end

  // Age of each slot relative to head. Anything older than or equal to the
  // mispredicted branch survives a flush; everything younger is dropped.
  always_comb begin
    flush_age = flush_idx - head;
    survive   = '0;
    entry_age = '0;
    for (int j = 0; j < NCOMMIT; j++) begin
      entry_age  = LNCOMMIT'(j) - head;
      survive[j] = (entry_age <= flush_age);
    end
  end

  assign done_merged = done | (done_set & valid);

  // Next-state selection. Flush wins over allocate and retire; completion
  // pulses for surviving entries are still captured during a flush.
  always_comb begin
    head_next         = head;
    tail_next         = tail;
    count_next        = count;
    valid_next        = valid;
    done_next         = done_merged;
    retire_mask_next  = '0;
    retire_count_next = '0;
    if (flush_valid) begin
      valid_next = valid & survive;
      done_next  = done_merged & valid & survive;
      tail_next  = flush_idx + LNCOMMIT'(1);
      count_next = {1'b0, flush_age} + (LNCOMMIT+1)'(1);
    end else begin
      valid_next        = (valid & ~ret_mask) | grant_mask;
      done_next         = done_merged & ~ret_mask & ~grant_mask;
      head_next         = head + ret_cnt;
      tail_next         = tail + alloc_k[LNCOMMIT-1:0] & {LNCOMMIT{alloc_ok}}
                        | tail & {LNCOMMIT{!alloc_ok}};
      count_next        = count + (alloc_ok ? alloc_k : '0)
                        - {1'b0, ret_cnt};
      retire_mask_next  = ret_mask;
      retire_count_next = ret_cnt;
    end
  end

  // State registers with synchronous reset; reset overrides every other
  // activity in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid        <= '0;
      done         <= '0;
      retire_mask  <= '0;
      retire_count <= '0;
    end else begin
      head         <= head_next;
      tail         <= tail_next;
      count        <= count_next;
      valid        <= valid_next;
      done         <= done_next;
      retire_mask  <= retire_mask_next;
      retire_count <= retire_count_next;
    end
  end

endmodule

// File: tb/tb_commit_ring_alloc.sv
// ---------------------------------------------------------------------------
// tb_commit_ring_alloc
//
// Purpose:
//   Self-checking bench for commit_ring_alloc. A reference model tracks the
//   ring as head + occupancy + a per-slot done flag; live entries are simply
//   the count slots starting at head. Directed scenarios walk through fill,
//   retire, wrap, flush, simultaneous alloc/retire and mid-run reset, then a
//   randomized phase mixes all of them.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_commit_ring_alloc;

  localparam int NCOMMIT  = 32;
  localparam int LNCOMMIT = 5;
  localparam int NDEC     = 4;
  localparam int NRETIRE  = 4;

  logic                     clk;
  logic                     reset;
  logic [NDEC-1:0]          alloc_req;
  logic                     alloc_ok;
  logic [NDEC*LNCOMMIT-1:0] alloc_idx;
  logic [NCOMMIT-1:0]       done_set;
  logic                     flush_valid;
  logic [LNCOMMIT-1:0]      flush_idx;
  logic [NCOMMIT-1:0]       retire_mask;
  logic [LNCOMMIT-1:0]      retire_count;
  logic [NCOMMIT-1:0]       commit_valid;
  logic [LNCOMMIT-1:0]      commit_head;
  logic [LNCOMMIT:0]        free_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          mHead;
  int          mCount;
  logic [31:0] mDone;
  logic [31:0] mRetMask;
  int          mRetCount;

  commit_ring_alloc #(
    .NCOMMIT(NCOMMIT), .LNCOMMIT(LNCOMMIT), .NDEC(NDEC), .NRETIRE(NRETIRE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .alloc_req(alloc_req),
    .alloc_ok(alloc_ok),
    .alloc_idx(alloc_idx),
    .done_set(done_set),
    .flush_valid(flush_valid),
    .flush_idx(flush_idx),
    .retire_mask(retire_mask),
    .retire_count(retire_count),
    .commit_valid(commit_valid),
    .commit_head(commit_head),
    .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Live-entry mask derived from head and occupancy
  function automatic logic [31:0] modelValid();
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < NCOMMIT; j++) begin
      if (((j - mHead + NCOMMIT) % NCOMMIT) < mCount) v[j] = 1'b1;
    end
    return v;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model for the current cycle
  task automatic checkOutput(input logic rstNow, input logic [3:0] req,
                             input logic fv);
    int k;
    logic expOk;
    logic [NDEC*LNCOMMIT-1:0] expIdx;
    k     = $countones(req);
    expOk = !rstNow && !fv && (k <= NCOMMIT - mCount);
    for (int i = 0; i < NDEC; i++) begin
      expIdx[i*LNCOMMIT +: LNCOMMIT] = LNCOMMIT'((mHead + mCount + i) % NCOMMIT);
    end
    checkVal("alloc_ok",     {63'd0, alloc_ok}, {63'd0, expOk});
    checkVal("alloc_idx",    64'(alloc_idx),    64'(expIdx));
    checkVal("free_count",   64'(free_count),   64'(NCOMMIT - mCount));
    checkVal("commit_valid", 64'(commit_valid), 64'(modelValid()));
    checkVal("commit_head",  64'(commit_head),  64'(mHead));
    checkVal("retire_mask",  64'(retire_mask),  64'(mRetMask));
    checkVal("retire_count", 64'(retire_count), 64'(mRetCount));
  endtask

  // Advance the model across one clock edge
  task automatic modelUpdate(input logic rstNow, input logic [3:0] req,
                             input logic [31:0] dset, input logic fv,
                             input int fidx);
    int k, r, age, tailOld;
    logic ok;
    logic [31:0] oldValid, rm;
    if (rstNow) begin
      mHead = 0; mCount = 0; mDone = '0; mRetMask = '0; mRetCount = 0;
      return;
    end
    k        = $countones(req);
    ok       = !fv && (k <= NCOMMIT - mCount);
    oldValid = modelValid();
    if (fv) begin
      age = (fidx - mHead + NCOMMIT) % NCOMMIT;
      for (int j = 0; j < NCOMMIT; j++) begin
        if (oldValid[j] && ((j - mHead + NCOMMIT) % NCOMMIT) <= age)
          mDone[j] = mDone[j] | dset[j];
        else
          mDone[j] = 1'b0;
      end
      mCount = age + 1;
      mRetMask = '0; mRetCount = 0;
    end else begin
      r = 0; rm = '0;
      while (r < NRETIRE && r < mCount && mDone[(mHead + r) % NCOMMIT]) begin
        rm[(mHead + r) % NCOMMIT] = 1'b1;
        r++;
      end
      tailOld = (mHead + mCount) % NCOMMIT;
      mDone = (mDone | (dset & oldValid)) & ~rm;
      if (ok) for (int i = 0; i < k; i++) mDone[(tailOld + i) % NCOMMIT] = 1'b0;
      mHead  = (mHead + r) % NCOMMIT;
      mCount = mCount - r + (ok ? k : 0);
      mRetMask = rm; mRetCount = r;
    end
  endtask

  // Drive one cycle of inputs, check, then step the clock
  task automatic applyStimulus(input logic rstNow, input logic [3:0] req,
                               input logic [31:0] dset, input logic fv,
                               input int fidx);
    reset       = rstNow;
    alloc_req   = req;
    done_set    = dset;
    flush_valid = fv;
    flush_idx   = LNCOMMIT'(fidx);
    #1;
    assert ((req & (req + 4'd1)) == 4'd0)
    else $error("[TB] illegal non-thermometer alloc_req %b", req);
    if (fv && !rstNow) begin
      assert (mCount > 0 && ((fidx - mHead + NCOMMIT) % NCOMMIT) < mCount)
      else $error("[TB] illegal flush_idx %0d", fidx);
    end
    checkOutput(rstNow, req, fv);
    modelUpdate(rstNow, req, dset, fv, fidx);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] dset);
    applyStimulus(1'b0, 4'b0000, dset, 1'b0, 0);
  endtask

  task automatic fillEntries(input int n);
    int left;
    left = n;
    while (left > 0) begin
      if (left >= 4) applyStimulus(1'b0, 4'b1111, '0, 1'b0, 0);
      else applyStimulus(1'b0, 4'((1 << left) - 1), '0, 1'b0, 0);
      left -= 4;
    end
  endtask

  initial begin
    int k, cyc;
    logic fv, rs;
    int fidx;

    reset = 1'b1; alloc_req = '0; done_set = '0; flush_valid = 1'b0; flush_idx = '0;
    mHead = 0; mCount = 0; mDone = '0; mRetMask = '0; mRetCount = 0;
    @(posedge clk); #1;

    // Fill the ring four at a time, then a request on a full ring is refused
    $display("[TB] fill to full");
    applyStimulus(1'b1, 4'b0000, '0, 1'b0, 0);
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 4'b1111, '0, 1'b0, 0);
    checkVal("full_free_count", 64'(free_count), 64'd0);
    checkVal("full_valid", 64'(commit_valid), 64'hFFFF_FFFF);
    applyStimulus(1'b0, 4'b0001, '0, 1'b0, 0);

    // Retire from full: two groups off the head
    $display("[TB] retire from full");
    idle(32'h0000_003F);
    idle('0);
    checkVal("retire_first_mask", 64'(retire_mask), 64'h0000_000F);
    checkVal("retire_first_head", 64'(commit_head), 64'd4);
    idle('0);
    checkVal("retire_second_mask", 64'(retire_mask), 64'h0000_0030);
    checkVal("retire_second_head", 64'(commit_head), 64'd6);
    checkVal("retire_second_free", 64'(free_count), 64'd6);

    // Wrap: move an empty ring to head=30 then allocate across the end
    $display("[TB] wrap-around");
    applyStimulus(1'b1, 4'b0000, '0, 1'b0, 0);
    fillEntries(30);
    idle(32'hFFFF_FFFF);
    cyc = 0;
    while (mCount > 0 && cyc < 20) begin idle('0); cyc++; end
    checkVal("drain_done", 64'(cyc < 20), 64'd1);
    checkVal("wrap_head", 64'(commit_head), 64'd30);
    applyStimulus(1'b0, 4'b1111, '0, 1'b0, 0);
    idle(32'hC000_0003);
    idle('0);
    checkVal("wrap_retire_mask", 64'(retire_mask), 64'hC000_0003);
    checkVal("wrap_head_after", 64'(commit_head), 64'd2);

    // Flush with a simultaneous request
    $display("[TB] flush");
    applyStimulus(1'b1, 4'b0000, '0, 1'b0, 0);
    fillEntries(10);
    applyStimulus(1'b0, 4'b0011, '0, 1'b1, 3);
    checkVal("flush_valid_mask", 64'(commit_valid), 64'h0000_000F);
    checkVal("flush_tail", 64'(alloc_idx[LNCOMMIT-1:0]), 64'd4);
    checkVal("flush_free", 64'(free_count), 64'd28);
    checkVal("flush_retire", 64'(retire_mask), 64'd0);

    // Allocate the last free slot while two entries retire
    $display("[TB] alloc and retire together");
    applyStimulus(1'b1, 4'b0000, '0, 1'b0, 0);
    fillEntries(31);
    idle(32'h0000_0003);
    applyStimulus(1'b0, 4'b0001, '0, 1'b0, 0);
    checkVal("simul_free", 64'(free_count), 64'd2);
    checkVal("simul_retire_count", 64'(retire_count), 64'd2);

    // Reset mid-run with a flush pending
    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 4'b0000, '0, 1'b0, 0);
    fillEntries(12);
    applyStimulus(1'b1, 4'b1111, '0, 1'b1, 5);
    checkVal("rst_valid", 64'(commit_valid), 64'd0);
    checkVal("rst_free", 64'(free_count), 64'd32);
    applyStimulus(1'b0, 4'b1111, '0, 1'b0, 0);

    // Randomized mix of everything
    $display("[TB] random phase");
    for (int c = 0; c < 600; c++) begin
      k  = $urandom_range(0, 4);
      rs = ($urandom_range(0, 99) == 0);
      fv = (mCount > 0) && ($urandom_range(0, 15) == 0);
      fidx = 0;
      if (fv) fidx = (mHead + $urandom_range(0, mCount - 1)) % NCOMMIT;
      applyStimulus(rs, 4'((1 << k) - 1), $urandom(), fv, fidx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
